cross_bar_mux_arbiter: RTL

CROSS_BAR_MUX_ARBITER -- requirements
Module: cross_bar_mux_arbiter

---
 rtl/cross_bar_mux_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/cross_bar_mux_arbiter.sv
// Packet-level N:1 AXI-Stream merge. A round-robin arbiter picks one source
// per packet, and that source owns the output until its tlast beat transfers.
module cross_bar_mux_arbiter #(
  parameter int SSEL_WIDTH = 2,
  parameter int CHANNEL_NO = 2**SSEL_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata [CHANNEL_NO],
  input  logic [CHANNEL_NO-1:0] s_axis_tvalid,
  input  logic [CHANNEL_NO-1:0] s_axis_tlast,
  output logic [CHANNEL_NO-1:0] s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [SSEL_WIDTH-1:0] m_axis_tid,
  input  logic                  m_axis_tready
);

  // One-hot style encoding so that both all-zero and all-one values are illegal.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [SSEL_WIDTH-1:0] grant_q, grant_d;
  logic [SSEL_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [SSEL_WIDTH-1:0] rr_pick;

  // The first requester at or after last+1, wrapping around.
  function automatic logic [SSEL_WIDTH-1:0] rr_search(
    input logic [CHANNEL_NO-1:0] req,
    input logic [SSEL_WIDTH-1:0] last
  );
    logic                  found;
    logic [SSEL_WIDTH-1:0] sel;
    logic [SSEL_WIDTH-1:0] pick;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < CHANNEL_NO; i++) begin
      sel = SSEL_WIDTH'((int'(last) + 1 + i) % CHANNEL_NO);
      if (!found && req[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
    return pick;
  endfunction

  assign rr_pick    = rr_search(s_axis_tvalid, last_grant_q);
  assign m_axis_tid = grant_q;

  always_ff @(posedge aclk) begin
    // NOTE: state registers use non-blocking assignments, so every register
    // samples its pre-edge value no matter what order the statements are in.
    if (areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= SSEL_WIDTH'(CHANNEL_NO - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          grant_d = rr_pick;
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        m_axis_tdata           = s_axis_tdata[grant_q];
        m_axis_tvalid          = s_axis_tvalid[grant_q];
        m_axis_tlast           = s_axis_tlast[grant_q];
        s_axis_tready[grant_q] = m_axis_tready;
        // The grant is released only after the tlast beat transfers.
        if (s_axis_tvalid[grant_q] && m_axis_tready && s_axis_tlast[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
